// File: rtl/asic_cellbist5.sv
// Exhaustive 32-pattern BIST driver/checker for five-input oa221/ao221 family cells.
// Drives are registered; z is compared LAT cycles after its pattern is driven.
module asic_cellbist5 #(
  parameter string FUNC = "OA221",
  parameter int    LAT  = 1,
  parameter string PROP = "DEFAULT"
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       a0,
  output logic       a1,
  output logic       b0,
  output logic       b1,
  output logic       c0,
  input  logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] fail_count,
  output logic [4:0] fail_vec
);

  localparam bit IS_AO  = (FUNC == "AO221") || (FUNC == "AOI221");
  localparam bit IS_INV = (FUNC == "OAI221") || (FUNC == "AOI221");
  localparam int PD     = (LAT > 0) ? LAT : 1;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DRAIN, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [4:0] pat_q, pat_d;
  logic [1:0] drn_q, drn_d;
  logic [5:0] fcnt_q, fcnt_d;
  logic [4:0] fvec_q, fvec_d;
  logic       first_q, first_d;
  // Pipeline entry: {valid, expected, pattern index}
  logic [6:0] pipe_q [PD];
  logic [6:0] pipe_d [PD];
  logic [6:0] stage0;
  logic [6:0] cmp;
  logic       gold_raw;
  logic       gold;

  always_comb begin
    if (IS_AO) gold_raw = (pat_q[0] & pat_q[1]) | (pat_q[2] & pat_q[3]) | pat_q[4];
    else       gold_raw = (pat_q[0] | pat_q[1]) & (pat_q[2] | pat_q[3]) & pat_q[4];
    gold   = gold_raw ^ IS_INV;
    stage0 = {state_q == S_DRIVE, gold, pat_q};
    cmp    = (LAT == 0) ? stage0 : pipe_q[PD-1];
    pipe_d[0] = stage0;
    for (int i = 1; i < PD; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    drn_d   = drn_q;
    fcnt_d  = fcnt_q;
    fvec_d  = fvec_q;
    first_d = first_q;

    if (cmp[6] && (z != cmp[5])) begin
      fcnt_d = fcnt_q + 6'd1;
      if (!first_q) begin
        fvec_d  = cmp[4:0];
        first_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DRIVE;
          pat_d   = 5'd0;
          fcnt_d  = 6'd0;
          fvec_d  = 5'd0;
          first_d = 1'b0;
        end
      end
      S_DRIVE: begin
        if (pat_q == 5'd31) begin
          pat_d   = 5'd0;
          drn_d   = 2'd0;
          state_d = (LAT > 0) ? S_DRAIN : S_DONE;
        end else begin
          pat_d = pat_q + 5'd1;
        end
      end
      S_DRAIN: begin
        // Hold off DONE until the last pattern's compare has landed
        if (drn_q == 2'(LAT - 1)) state_d = S_DONE;
        else                      drn_d   = drn_q + 2'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pat_q   <= 5'd0;
      drn_q   <= 2'd0;
      fcnt_q  <= 6'd0;
      fvec_q  <= 5'd0;
      first_q <= 1'b0;
      for (int i = 0; i < PD; i++) pipe_q[i] <= 7'd0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      drn_q   <= drn_d;
      fcnt_q  <= fcnt_d;
      fvec_q  <= fvec_d;
      first_q <= first_d;
      for (int i = 0; i < PD; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign a0         = pat_q[0];
  assign a1         = pat_q[1];
  assign b0         = pat_q[2];
  assign b1         = pat_q[3];
  assign c0         = pat_q[4];
  assign busy       = (state_q == S_DRIVE) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign pass       = done && (fcnt_q == 6'd0);
  assign fail_count = fcnt_q;
  assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_asic_cellbist5.sv
// Directed bench: four BIST instances (OA221 LAT1/LAT0/LAT3, AOI221 LAT1) against cell models.
module tb_asic_cellbist5;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] st;
  logic [4:0] drv [4];
  logic       z [4];
  logic       busy_w [4];
  logic       done_w [4];
  logic       pass_w [4];
  logic [5:0] fc_w [4];
  logic [4:0] fv_w [4];
  int         zmode;
  int         n_chk;
  int         n_bad;

  always #5 clk = ~clk;

  function automatic logic oa(input logic [4:0] p);
    return (p[0] | p[1]) & (p[2] | p[3]) & p[4];
  endfunction
  function automatic logic ao(input logic [4:0] p);
    return (p[0] & p[1]) | (p[2] & p[3]) | p[4];
  endfunction

  asic_cellbist5 #(.FUNC("OA221"), .LAT(1), .PROP("DEFAULT")) u_oa1 (
    .clk(clk), .reset(reset), .start(st[0]),
    .a0(drv[0][0]), .a1(drv[0][1]), .b0(drv[0][2]), .b1(drv[0][3]), .c0(drv[0][4]),
    .z(z[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .fail_count(fc_w[0]), .fail_vec(fv_w[0]));

  asic_cellbist5 #(.FUNC("AOI221"), .LAT(1), .PROP("DEFAULT")) u_aoi (
    .clk(clk), .reset(reset), .start(st[1]),
    .a0(drv[1][0]), .a1(drv[1][1]), .b0(drv[1][2]), .b1(drv[1][3]), .c0(drv[1][4]),
    .z(z[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .fail_count(fc_w[1]), .fail_vec(fv_w[1]));

  asic_cellbist5 #(.FUNC("OA221"), .LAT(0), .PROP("DEFAULT")) u_l0 (
    .clk(clk), .reset(reset), .start(st[2]),
    .a0(drv[2][0]), .a1(drv[2][1]), .b0(drv[2][2]), .b1(drv[2][3]), .c0(drv[2][4]),
    .z(z[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
    .fail_count(fc_w[2]), .fail_vec(fv_w[2]));

  asic_cellbist5 #(.FUNC("OA221"), .LAT(3), .PROP("DEFAULT")) u_l3 (
    .clk(clk), .reset(reset), .start(st[3]),
    .a0(drv[3][0]), .a1(drv[3][1]), .b0(drv[3][2]), .b1(drv[3][3]), .c0(drv[3][4]),
    .z(z[3]), .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]),
    .fail_count(fc_w[3]), .fail_vec(fv_w[3]));

  // Cell models: registered OA221 (with stuck-at override), registered non-inverting AO221,
  // combinational OA221, and a three-stage OA221.
  logic z0_q, z1_q;
  logic [2:0] z3_sr;
  always @(posedge clk) begin
    z0_q  <= oa(drv[0]);
    z1_q  <= ao(drv[1]);
    z3_sr <= {z3_sr[1:0], oa(drv[3])};
  end
  assign z[0] = (zmode == 1) ? 1'b0 : (zmode == 2) ? 1'b1 : z0_q;
  assign z[1] = z1_q;
  assign z[2] = oa(drv[2]);
  assign z[3] = z3_sr[2];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One run on instance sel; start sampled at the edge ending cycle 0, held through cycle hold-1.
  task automatic run(input int sel, input int lat, input int hold, input int e_fc,
                     input int e_fv, input int e_pass, input string tag);
    int done_cyc = -1;
    int busy_bad = 0;
    int fc_at1   = -1;
    @(negedge clk) st[sel] = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (cyc >= hold) st[sel] = 1'b0;
      if (cyc == 1) fc_at1 = int'(fc_w[sel]);
      if (busy_w[sel] && done_w[sel]) busy_bad++;
      if (busy_w[sel] != (cyc <= 32 + lat)) busy_bad++;
      if (done_w[sel]) begin
        done_cyc = cyc;
        break;
      end
    end
    st[sel] = 1'b0;
    chk({tag, "_done_cyc"}, done_cyc, 33 + lat);
    chk({tag, "_busy_win"}, busy_bad, 0);
    chk({tag, "_fc_clear"}, fc_at1, 0);
    chk({tag, "_pass"}, pass_w[sel], e_pass);
    chk({tag, "_fail_count"}, fc_w[sel], e_fc);
    chk({tag, "_fail_vec"}, fv_w[sel], e_fv);
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    zmode = 0;
    st    = 4'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy_w[0], 0);
    chk("rst_done", done_w[0], 0);
    chk("rst_pass", pass_w[0], 0);
    chk("rst_fc", fc_w[0], 0);
    chk("rst_fv", fv_w[0], 0);
    chk("rst_drv", drv[0], 0);

    run(0, 1, 1, 0, 0, 1, "oa_ideal");
    zmode = 1;
    run(0, 1, 1, 9, 21, 0, "oa_stuck0");
    zmode = 2;
    run(0, 1, 1, 23, 0, 0, "oa_stuck1");
    zmode = 0;
    run(0, 1, 1, 0, 0, 1, "oa_rerun");
    run(1, 1, 1, 32, 0, 0, "aoi_vs_ao");
    run(2, 0, 1, 0, 0, 1, "lat0");
    run(3, 3, 1, 0, 0, 1, "lat3");

    // Reset in cycle 10 of a failing run, then a clean run from IDLE.
    zmode = 1;
    @(negedge clk) st[0] = 1'b1;
    @(negedge clk) st[0] = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_busy", busy_w[0], 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", busy_w[0], 0);
    chk("rst_mid_done", done_w[0], 0);
    chk("rst_mid_pass", pass_w[0], 0);
    chk("rst_mid_fc", fc_w[0], 0);
    chk("rst_mid_fv", fv_w[0], 0);
    chk("rst_mid_drv", drv[0], 0);
    zmode = 0;
    repeat (2) @(negedge clk);
    chk("idle_stays", busy_w[0], 0);
    run(0, 1, 1, 0, 0, 1, "after_rst");

    // start held high across most of the run must not restart it
    run(0, 1, 30, 0, 0, 1, "start_held");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
